// File: rtl/dm_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface dm_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 16
) ();

  // Port 0: processor load/store unit
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdat0;
  logic          ack0;
  logic [DW-1:0] rdat0;

  // Port 1: debug/DMA loader
  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdat1;
  logic          ack1;
  logic [DW-1:0] rdat1;

  // Data memory side
  logic          dmWrite;
  logic [DW-1:0] dmWrDat;
  logic [AW-1:0] dmWrDat_addr;
  logic [AW-1:0] dmReDat_addr;
  logic [DW-1:0] dmReDat;

  // Status
  logic          busy;

  modport slave (
    input  req0, we0, addr0, wdat0,
    input  req1, we1, addr1, wdat1,
    input  dmReDat,
    output ack0, rdat0,
    output ack1, rdat1,
    output dmWrite, dmWrDat, dmWrDat_addr, dmReDat_addr,
    output busy
  );

  modport master (
    output req0, we0, addr0, wdat0,
    output req1, we1, addr1, wdat1,
    output dmReDat,
    input  ack0, rdat0,
    input  ack1, rdat1,
    input  dmWrite, dmWrDat, dmWrDat_addr, dmReDat_addr,
    input  busy
  );

endinterface

// File: rtl/dm_arbiter.sv
// Two-port arbiter/sequencer in front of the 1K x 16 data memory.
// Each granted access walks IDLE -> ACCESS -> DONE, one cycle per state:
// the request is sampled in IDLE, the memory is driven in ACCESS and the
// winner sees a one-cycle ack (with read data for reads) in DONE.
// Every output comes straight from a register.
module dm_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 16,
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  dm_arbiter_if.slave   bus
);

  localparam bit RR_EN = (FIXED_PRIO == 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state_q;
  logic          rr_q;       // port that wins the next simultaneous request
  logic          win_q;      // latched winner id (0 = port 0, 1 = port 1)
  logic          we_q;       // latched direction of the in-flight access
  logic [AW-1:0] addr_q;     // latched address; also drives both memory addresses
  logic [DW-1:0] wdat_q;     // latched write data; also drives dmWrDat
  logic          dmWrite_q;
  logic          ack0_q;
  logic          ack1_q;
  logic [DW-1:0] rdat0_q;
  logic [DW-1:0] rdat1_q;
  logic          busy_q;

  logic          any_req;
  logic          gnt1_d;
  logic          rr_d;
  logic          we_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdat_d;

  // Winner selection and next round-robin pointer, evaluated for the IDLE cycle.
  always_comb begin
    any_req = bus.req0 | bus.req1;
    gnt1_d  = 1'b0;
    rr_d    = rr_q;
    if (bus.req0 && bus.req1) begin
      // Contention: the pointer decides in round-robin mode, port 0 otherwise.
      gnt1_d = RR_EN ? rr_q : 1'b0;
      // Only a contested grant moves the pointer, to the port that lost.
      if (RR_EN) begin
        rr_d = ~gnt1_d;
      end
    end else begin
      gnt1_d = bus.req1;
    end
    we_d   = gnt1_d ? bus.we1   : bus.we0;
    addr_d = gnt1_d ? bus.addr1 : bus.addr0;
    wdat_d = gnt1_d ? bus.wdat1 : bus.wdat0;
  end

  // Sequencer FSM with registered memory strobes, acks and read-data capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Any in-flight access is abandoned without an ack.
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      win_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdat_q    <= '0;
      dmWrite_q <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      rdat0_q   <= '0;
      rdat1_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ack0_q    <= 1'b0;
          ack1_q    <= 1'b0;
          dmWrite_q <= 1'b0;
          if (any_req) begin
            // Latch the winner's request; the memory-side registers load
            // here so the memory sees the access throughout ACCESS.
            win_q     <= gnt1_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdat_q    <= wdat_d;
            rr_q      <= rr_d;
            dmWrite_q <= we_d;
            busy_q    <= 1'b1;
            state_q   <= ACCESS;
          end
        end

        ACCESS: begin
          // The strobe is confined to this one cycle; address and data hold.
          dmWrite_q <= 1'b0;
          // Memory read data is combinational from addr_q, so it is valid now.
          if (!we_q) begin
            if (win_q) begin
              rdat1_q <= bus.dmReDat;
            end else begin
              rdat0_q <= bus.dmReDat;
            end
          end
          ack0_q  <= ~win_q;
          ack1_q  <= win_q;
          state_q <= DONE;
        end

        DONE: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          dmWrite_q <= 1'b0;
          ack0_q    <= 1'b0;
          ack1_q    <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign bus.dmWrite      = dmWrite_q;
  assign bus.dmWrDat      = wdat_q;
  assign bus.dmWrDat_addr = addr_q;
  assign bus.dmReDat_addr = addr_q;
  assign bus.ack0         = ack0_q;
  assign bus.ack1         = ack1_q;
  assign bus.rdat0        = rdat0_q;
  assign bus.rdat1        = rdat1_q;
  assign bus.busy         = busy_q;

endmodule
